// File: rtl/conv_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_axi_pkg
// Description : Shared types and constants for the convolution accelerator
//               AXI4-Lite write initiator: FSM state encoding, register
//               offsets inside the accelerator slave, and fixed AXI fields.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package conv_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_ADDR  = 3'd1,
        ST_CMD_RESP  = 3'd2,
        ST_PIX_FETCH = 3'd3,
        ST_PIX_ADDR  = 3'd4,
        ST_PIX_RESP  = 3'd5,
        ST_FIN       = 3'd6
    } wr_state_e;

    localparam logic [31:0] CMD_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] DATA_OFFSET  = 32'h0000_0004;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [2:0]  AXI_PROT_DEF = 3'b000;
    localparam logic [3:0]  AXI_STRB_ALL = 4'hF;

endpackage : conv_axi_pkg
`default_nettype wire

// File: rtl/axi_lite_wr_chan.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_wr_chan
// Description : AW/W valid tracking for a single AXI4-Lite write. A launch
//               pulse raises both valids; each channel drops its valid on the
//               edge of its own handshake and stays low while the other
//               channel is still waiting. A channel whose valid is low after
//               launch is therefore "done".
// Ports       : clk, reset (async, active-low)
//               launch            - start a new write (both valids rise)
//               awready, wready   - slave readies
//               awvalid, wvalid   - registered valids to the slave
//               both_done         - both channels done or completing now;
//                                   only meaningful after a launch
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_wr_chan (
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic awvalid_q, awvalid_d;
    logic wvalid_q,  wvalid_d;
    logic aw_done,   w_done;

    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        if (launch) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else begin
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q  && wready)  wvalid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    // A channel counts as done once its valid has dropped, or in the very
    // cycle its handshake completes, so the FSM can leave the address phase
    // in the same cycle as the final handshake.
    assign aw_done   = !awvalid_q || awready;
    assign w_done    = !wvalid_q  || wready;
    assign both_done = aw_done && w_done;

    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;

endmodule : axi_lite_wr_chan
`default_nettype wire

// File: rtl/conv_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : conv_axi4_lite_master
// Description : AXI4-Lite write initiator that loads one image into the
//               convolution accelerator. On start it writes a clear command
//               to the command offset, then writes each upstream pixel to
//               the data offset, waiting for every B response before the
//               next write, and finally pulses done.
// Ports       : clk, reset (async, active-low)
//               start / busy / done / err          - frame control/status
//               pix_valid / pix_ready / pix_data   - upstream pixel stream
//               axi_aw*, axi_w*, axi_b*            - AXI4-Lite write channels
// Revision    : 1.0 - initial release
// ============================================================================
module conv_axi4_lite_master
    import conv_axi_pkg::*;
#(
    parameter int          N         = 7,
    parameter int          IMG       = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [N:0]    pix_data,
    output logic          axi_awvalid,
    input  logic          axi_awready,
    output logic [31:0]   axi_awaddr,
    output logic [2:0]    axi_awprot,
    output logic          axi_wvalid,
    input  logic          axi_wready,
    output logic [31:0]   axi_wdata,
    output logic [3:0]    axi_wstrb,
    input  logic          axi_bvalid,
    output logic          axi_bready,
    input  logic [1:0]    axi_bresp
);

    localparam int                PIX_TOTAL = IMG * IMG;
    localparam int                CNT_W     = $clog2(PIX_TOTAL) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PIX_TOTAL);

    wr_state_e          state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               err_q,    err_d;
    logic [31:0]        awaddr_q, awaddr_d;
    logic [31:0]        wdata_q,  wdata_d;
    logic               launch;
    logic               both_done;
    logic [CNT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Write channel tracker, shared by the command and pixel writes
    // ------------------------------------------------------------------
    axi_lite_wr_chan u_wr_chan (
        .clk       (clk),
        .reset     (reset),
        .launch    (launch),
        .awready   (axi_awready),
        .wready    (axi_wready),
        .awvalid   (axi_awvalid),
        .wvalid    (axi_wvalid),
        .both_done (both_done)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        launch   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CMD_ADDR;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    awaddr_d = BASE_ADDR + CMD_OFFSET;
                    wdata_d  = 32'h0;
                    launch   = 1'b1;
                end
            end
            ST_CMD_ADDR: begin
                if (both_done) state_d = ST_CMD_RESP;
            end
            ST_CMD_RESP: begin
                if (axi_bvalid) begin
                    if (axi_bresp != RESP_OKAY) err_d = 1'b1;
                    state_d = ST_PIX_FETCH;
                end
            end
            ST_PIX_FETCH: begin
                if (pix_valid) begin
                    wdata_d  = 32'(pix_data);
                    awaddr_d = BASE_ADDR + DATA_OFFSET;
                    launch   = 1'b1;
                    state_d  = ST_PIX_ADDR;
                end
            end
            ST_PIX_ADDR: begin
                if (both_done) state_d = ST_PIX_RESP;
            end
            ST_PIX_RESP: begin
                if (axi_bvalid) begin
                    if (axi_bresp != RESP_OKAY) err_d = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == LAST_CNT) ? ST_FIN : ST_PIX_FETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            awaddr_q <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done       = (state_q == ST_FIN);
    assign err        = err_q;
    assign pix_ready  = (state_q == ST_PIX_FETCH);
    assign axi_bready = (state_q == ST_CMD_RESP) || (state_q == ST_PIX_RESP);
    assign axi_awaddr = awaddr_q;
    assign axi_wdata  = wdata_q;
    assign axi_awprot = AXI_PROT_DEF;
    assign axi_wstrb  = AXI_STRB_ALL;

endmodule : conv_axi4_lite_master
`default_nettype wire

// File: tb/tb_conv_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_axi4_lite_master
// Description : Self-checking bench for conv_axi4_lite_master (IMG=4). A
//               table of frame scenarios (slave ready delays, error response
//               position, pixel-source gap, mid-frame start) is applied in a
//               loop; a scoreboard holds the expected writes pushed as the
//               command and each pixel are issued. A hand-written sequence
//               covers reset in the middle of a frame.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_axi4_lite_master;

    localparam int          N    = 7;
    localparam int          IMG  = 4;
    localparam int          NPIX = IMG * IMG;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, start, busy, done, err;
    logic        pix_valid, pix_ready;
    logic [N:0]  pix_data;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready;
    logic [31:0] axi_awaddr, axi_wdata;
    logic [2:0]  axi_awprot;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp;

    always #5 clk = ~clk;

    conv_axi4_lite_master #(.N(N), .IMG(IMG), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    typedef struct {
        int   aw_dly;
        int   w_dly;
        int   err_pix;
        int   gap_at;
        int   gap_len;
        int   mid_start;
        int   exp_writes;
        logic exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl [6];
    wr_t  sb [$];

    int checks = 0;
    int errors = 0;

    // slave / source model state
    int          aw_dly, w_dly, err_pix, gap_at, gap_len;
    int          aw_wait, w_wait, writes, pix_wr, b_cnt, next_pix, gap_ctr;
    bit          aw_taken, w_taken, b_pend, b_err;
    bit          prev_aw_hs, prev_w_hs, prev_awv, prev_wv, prev_b_hs, prev_b_err, prev_bready;
    logic [31:0] cap_addr, cap_data, prev_awaddr, prev_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        aw_wait = 0; w_wait = 0; writes = 0; pix_wr = 0; b_cnt = 0;
        next_pix = 1; gap_ctr = 0;
        aw_taken = 0; w_taken = 0; b_pend = 0; b_err = 0;
        prev_aw_hs = 0; prev_w_hs = 0; prev_awv = 0; prev_wv = 0;
        prev_b_hs = 0; prev_b_err = 0; prev_bready = 0;
        prev_awaddr = '0; prev_wdata = '0; cap_addr = '0; cap_data = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        pix_valid = 1'b0; pix_data = '0;
    endtask

    // One slave/source step, run on every falling edge. Handshakes computed
    // here are the ones the next rising edge will complete.
    task automatic slave_step();
        bit  aw_hs, w_hs, b_hs, gap;
        wr_t e;
        if (prev_aw_hs) chk("aw_drop", 32'(axi_awvalid), 32'd0);
        else if (prev_awv) begin
            chk("aw_hold", 32'(axi_awvalid), 32'd1);
            chk("awaddr_hold", axi_awaddr, prev_awaddr);
        end
        if (prev_w_hs) chk("w_drop", 32'(axi_wvalid), 32'd0);
        else if (prev_wv) begin
            chk("w_hold", 32'(axi_wvalid), 32'd1);
            chk("wdata_hold", axi_wdata, prev_wdata);
        end
        if (prev_b_hs) begin
            b_pend = 0; axi_bvalid = 1'b0; axi_bresp = 2'b00; b_cnt++;
            if (prev_b_err) chk("err_rise", 32'(err), 32'd1);
        end

        axi_awready = axi_awvalid ? (aw_wait >= aw_dly) : (aw_dly == 0);
        if (axi_awvalid && !axi_awready) aw_wait++;
        aw_hs = axi_awvalid && axi_awready;
        if (aw_hs) begin
            chk("one_outstanding", {30'd0, b_pend, aw_taken}, 32'd0);
            aw_taken = 1; cap_addr = axi_awaddr; aw_wait = 0;
        end
        axi_wready = axi_wvalid ? (w_wait >= w_dly) : (w_dly == 0);
        if (axi_wvalid && !axi_wready) w_wait++;
        w_hs = axi_wvalid && axi_wready;
        if (w_hs) begin
            chk("w_single", {31'd0, w_taken}, 32'd0);
            w_taken = 1; cap_data = axi_wdata; w_wait = 0;
        end

        if (aw_taken && w_taken) begin
            aw_taken = 0; w_taken = 0;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow actual=write addr %0h required=no write", cap_addr);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", cap_addr, e.addr);
                chk("wr_data", cap_data, e.data);
            end
            writes++;
            if (cap_addr == BASE + 32'd4) pix_wr++;
            b_err  = (cap_addr == BASE + 32'd4) && (pix_wr == err_pix);
            b_pend = 1;
        end

        if (b_pend && !axi_bvalid && prev_bready) begin
            axi_bvalid = 1'b1;
            axi_bresp  = b_err ? 2'b10 : 2'b00;
        end
        b_hs = axi_bvalid && axi_bready;
        if (b_hs && b_err) chk("err_pre", 32'(err), 32'd0);

        gap = (gap_len > 0) && (next_pix == gap_at + 1) && (gap_ctr < gap_len);
        pix_valid = !gap && (next_pix <= NPIX);
        pix_data  = next_pix[N:0];
        if (gap && pix_ready) begin
            gap_ctr++;
            chk("stall_awvalid", 32'(axi_awvalid), 32'd0);
            chk("stall_wvalid", 32'(axi_wvalid), 32'd0);
        end
        if (pix_valid && pix_ready) begin
            sb.push_back({BASE + 32'd4, 32'(next_pix)});
            next_pix++;
        end

        prev_aw_hs = aw_hs; prev_awv = axi_awvalid; prev_awaddr = axi_awaddr;
        prev_w_hs  = w_hs;  prev_wv  = axi_wvalid;  prev_wdata  = axi_wdata;
        prev_b_hs  = b_hs;  prev_b_err = b_hs && b_err; prev_bready = axi_bready;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            slave_step();
        end
    end

    task automatic pulse_start();
        sb.push_back({BASE, 32'h0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_t1", 32'(busy), 32'd1);
        chk("valids_t1", {30'd0, axi_awvalid, axi_wvalid}, 32'd3);
        chk("err_cleared", 32'(err), 32'd0);
        chk("awprot", 32'(axi_awprot), 32'd0);
        chk("wstrb", 32'(axi_wstrb), 32'hF);
    endtask

    task automatic run_frame(input int i);
        int dcnt;
        @(negedge clk);
        model_clear();
        aw_dly = tbl[i].aw_dly; w_dly = tbl[i].w_dly; err_pix = tbl[i].err_pix;
        gap_at = tbl[i].gap_at; gap_len = tbl[i].gap_len;
        pulse_start();
        dcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = (tbl[i].mid_start != 0) && (c == 30);
            if (done) begin
                dcnt++;
                break;
            end
            chk("busy_in_frame", 32'(busy), 32'd1);
        end
        start = 1'b0;
        if (dcnt == 0) begin
            checks++; errors++;
            $display("FAIL frame%0d_timeout actual=no done required=done", i);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("done_once", 32'(dcnt), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("writes", 32'(writes), 32'(tbl[i].exp_writes));
        chk("b_count", 32'(b_cnt), 32'(tbl[i].exp_writes));
        chk("err_end", 32'(err), 32'(tbl[i].exp_err));
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //           aw  w  errp gapat gaplen mid writes err
        tbl[0] = '{0, 0, 0, 0, 0,  0, NPIX + 1, 1'b0};  // ideal slave
        tbl[1] = '{0, 5, 0, 0, 0,  0, NPIX + 1, 1'b0};  // W well after AW
        tbl[2] = '{4, 0, 0, 0, 0,  0, NPIX + 1, 1'b0};  // W before AW
        tbl[3] = '{0, 0, 3, 0, 0,  0, NPIX + 1, 1'b1};  // SLVERR on pixel 3
        tbl[4] = '{0, 0, 0, 8, 10, 1, NPIX + 1, 1'b0};  // source gap + stray start
        tbl[5] = '{2, 2, 0, 0, 0,  0, NPIX + 1, 1'b0};  // both ready together, delayed

        reset = 1'b0;
        start = 1'b0;
        model_clear();
        aw_dly = 0; w_dly = 0; err_pix = 0; gap_at = 0; gap_len = 0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 32'(axi_awvalid), 32'd0);
        chk("rst_wvalid", 32'(axi_wvalid), 32'd0);
        chk("rst_bready", 32'(axi_bready), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        chk("rst_awaddr", axi_awaddr, 32'd0);
        chk("rst_wdata", axi_wdata, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(i);

        // Reset while the write for pixel 7 is in flight.
        @(negedge clk);
        model_clear();
        aw_dly = 0; w_dly = 0; err_pix = 0; gap_at = 0; gap_len = 0;
        pulse_start();
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if (axi_awvalid && pix_wr == 6) begin
                    hit = 1;
                    break;
                end
            end
            if (!hit) begin
                checks++; errors++;
                $display("FAIL rst_mid_reach actual=pixel7 not issued required=pixel7 awvalid");
            end
        end
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd0);
        chk("mid_rst_ready", {30'd0, axi_bready, pix_ready}, 32'd0);
        chk("mid_rst_status", {29'd0, busy, done, err}, 32'd0);
        chk("mid_rst_awaddr", axi_awaddr, 32'd0);
        chk("mid_rst_wdata", axi_wdata, 32'd0);
        model_clear();
        @(negedge clk);
        #2 reset = 1'b1;
        run_frame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_conv_axi4_lite_master
`default_nettype wire

// File: doc/conv_axi4_lite_master.md
# conv_axi4_lite_master

AXI4-Lite write initiator that loads one image into the convolution accelerator's AXI4-Lite slave. On `start` it issues a clear-command write to the command offset, then streams every pixel from an upstream pixel source as one data-offset write per pixel. It completes each B response before the next write, then pulses `done`. It sits between the image buffer/DMA side and the accelerator's slave port.

## Interface
Parameters:
- `N` = 7: pixel MSB index; pixel width N+1.
- `IMG` = 32: padded image side (im + stride − 1); pixels per frame = IMG*IMG.
- `BASE_ADDR` = 32'h0000_0000: accelerator base address; low nibble must be 0.

Ports:
- `clk` in 1: clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame request; honoured only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last pixel's B handshake.
- `err` out 1: sticky; set on any `axi_bresp` ≠ 2'b00; cleared only by `start` or reset.
- `pix_valid` in 1, `pix_ready` out 1, `pix_data` in N+1: upstream pixel stream, valid/ready.
- `axi_awvalid` out 1, `axi_awready` in 1, `axi_awaddr` out 32, `axi_awprot` out 3 (always 3'b000).
- `axi_wvalid` out 1, `axi_wready` in 1, `axi_wdata` out 32, `axi_wstrb` out 4 (always 4'hF).
- `axi_bvalid` in 1, `axi_bready` out 1, `axi_bresp` in 2.

## Operation
- States: IDLE, CMD_ADDR, CMD_RESP, PIX_FETCH, PIX_ADDR, PIX_RESP, FIN.
- IDLE: `start` → CMD_ADDR. Clears `err` and the pixel counter.
- CMD_ADDR: `awaddr`=BASE_ADDR, `wdata`=0. AW and W are tracked independently with per-channel done flags. Each valid drops the cycle after its own handshake. When both are done → CMD_RESP.
- CMD_RESP: `bready`=1. On `bvalid` → PIX_FETCH.
- PIX_FETCH: `pix_ready`=1. On `pix_valid` the pixel is registered, zero-extended to 32 bits, into `wdata` → PIX_ADDR.
- PIX_ADDR: `awaddr`=BASE_ADDR+4. Same dual-channel rule as CMD_ADDR → PIX_RESP.
- PIX_RESP: `bready`=1. On `bvalid` the counter increments. If the count reaches IMG*IMG → FIN, else → PIX_FETCH.
- FIN: `done`=1 for one cycle → IDLE.
- Exactly one outstanding transaction at any time. The read channel is not driven by this block.

## Timing
- Reset values: all valids, `pix_ready`, `bready`, `busy`, `done`, `err` = 0. `awaddr`=0, `wdata`=0. State IDLE, counter 0.
- `start` at cycle t → `awvalid`=`wvalid`=1 at t+1.
- Once asserted, AWVALID/WVALID and their payloads hold stable until their handshake. They never depend combinationally on the ready inputs.
- AW and W handshakes may complete in the same cycle or in either order. A channel that is already done stays deasserted while it waits for the other.
- Minimum per-pixel period is 3 cycles: fetch, AW/W, B. A stalled `wready` (the slave deasserts it while the engine is not requesting data) only extends PIX_ADDR.
- `bvalid` is ignored outside the RESP states. `err` updates in the same edge as the B handshake.
- `start` while busy is ignored.
- `pix_valid` outside PIX_FETCH is not consumed.
- Counter width is clog2(IMG*IMG)+1. There is no wrap within a frame.
- Reset mid-frame: everything returns to reset values at once, with no completion of the in-flight transaction. A subsequent `start` restarts with the command write.

## Structure
- Package `conv_axi_pkg`: state enum `wr_state_e`, `CMD_OFFSET`=32'h0, `DATA_OFFSET`=32'h4, `RESP_OKAY`=2'b00, `AXI_PROT_DEF`=3'b000.
- Optional sub-module `axi_lite_wr_chan`: holds AW/W valid and done flags for one write and emits `both_done`. It is reused by CMD_ADDR and PIX_ADDR. Everything else is a single FSM.

## Test plan
- Ideal slave (ready always 1, bvalid the cycle after bready), IMG=4: `start` → 1 write to addr 0 with wdata 0, then 16 writes to addr 4 carrying pixels 1..16 in order. `done` pulses exactly once. `busy` is high until then.
- Slave asserts `wready` 5 cycles after `awready`: AW drops after its handshake, W holds stable with the same data, and exactly one B is consumed.
- `wready` before `awready`, and both in the same cycle: each produces exactly one transaction per pixel, with no duplicate or lost write.
- `axi_bresp`=2'b10 on pixel 3: `err` rises on that B edge, the frame still completes all 16 pixels, and `err` clears on the next `start`.
- `pix_valid` low for 10 cycles mid-frame: the FSM waits in PIX_FETCH with all AXI valids at 0. `start` pulsed during the frame has no effect.
- `reset` asserted while `awvalid`=1 on pixel 7: all outputs go to 0 asynchronously. After release and `start`, the command write is reissued and 16 pixel writes follow.
